// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-outstanding word requests
// to instruction memory and hands each fetched instruction to decode.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [4:0]      instr_opcode,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault,
    output logic            fault_cause
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fault_q, fault_d;
    logic            cause_q, cause_d;

    logic            req_fire;
    logic            outstanding;
    logic            rdr_misaligned;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        kill_d         = kill_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = instr_valid_q;
        fault_d        = fault_q;
        cause_d        = cause_q;
        req_fire       = (state_q == S_REQ) && imem_req_ready;
        rdr_misaligned = (redirect_pc[1:0] != 2'b00);
        // A response is still owed after this edge if one is accepted now, or if the
        // one already in flight does not arrive this cycle.
        outstanding    = req_fire ||
                         (((state_q == S_WAIT) || ((state_q == S_FAULT) && kill_q)) && !imem_rsp_valid);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        if (imem_rsp_data[1:0] != 2'b11) begin
                            fault_d = 1'b1;
                            cause_d = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            instr_valid_d = 1'b1;
                            state_d       = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_FAULT: begin
                if (imem_rsp_valid && kill_q) begin
                    kill_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above, including a response captured this cycle.
        if (redirect_valid && (state_q != S_IDLE)) begin
            pc_d          = redirect_pc;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            kill_d        = outstanding;
            cause_d       = cause_q;
            if (rdr_misaligned) begin
                fault_d = 1'b1;
                cause_d = 1'b0;
                state_d = S_FAULT;
            end else begin
                fault_d = 1'b0;
                state_d = outstanding ? S_WAIT : S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VECTOR;
            kill_q        <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            cause_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            cause_q       <= cause_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_opcode   = instr_q[6:2];
    assign instr_pc       = instr_pc_q;
    assign fetch_fault    = fault_q;
    assign fault_cause    = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle vector bench for fetch_unit with a small instruction memory model,
// plus a second instance exercising PC wrap from a top-of-memory reset vector.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, rsp_valid, iv, ir, rdr_v, fault, cause;
    logic [31:0] req_addr, rsp_data, instr, ipc, rdr_pc;
    logic [4:0]  opcode;

    logic        w_rst_n, w_req_valid, w_req_ready, w_rsp_valid, w_iv, w_ir, w_rdr_v, w_fault, w_cause;
    logic [31:0] w_req_addr, w_rsp_data, w_instr, w_ipc, w_rdr_pc;
    logic [4:0]  w_opcode;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(iv), .instr_ready(ir), .instr(instr), .instr_opcode(opcode), .instr_pc(ipc),
        .redirect_valid(rdr_v), .redirect_pc(rdr_pc),
        .fetch_fault(fault), .fault_cause(cause)
    );

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_iv), .instr_ready(w_ir), .instr(w_instr), .instr_opcode(w_opcode), .instr_pc(w_ipc),
        .redirect_valid(w_rdr_v), .redirect_pc(w_rdr_pc),
        .fetch_fault(w_fault), .fault_cause(w_cause)
    );

    typedef struct {
        logic        rst_n, rr, ir, rv;
        logic [31:0] rpc;
        int          lat;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] eipc, einstr;
        logic        ef, ec;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // memory model state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;
    int          cur_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h000: return 32'h0050_0093;
            32'h004: return 32'h00A0_0113;
            32'h100: return 32'h0010_0513;
            32'h200: return 32'h0020_0593;
            32'h204: return 32'h0000_4501;
            default: return 32'h0000_0013;
        endcase
    endfunction

    task automatic add(input logic r, rr_i, ir_i, rv_i, input logic [31:0] rpc_i, input int lat_i,
                       input logic ereq_i, input logic [31:0] eaddr_i, input logic eiv_i,
                       input logic [31:0] eipc_i, einstr_i, input logic ef_i, ec_i);
        vec_t v;
        v.rst_n = r; v.rr = rr_i; v.ir = ir_i; v.rv = rv_i; v.rpc = rpc_i; v.lat = lat_i;
        v.ereq = ereq_i; v.eaddr = eaddr_i; v.eiv = eiv_i; v.eipc = eipc_i; v.einstr = einstr_i;
        v.ef = ef_i; v.ec = ec_i;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        else n_pass++;
    endtask

    // One clock of the main DUT with the memory model answering accepted requests.
    task automatic tick();
        logic acc;
        logic [31:0] a;
        acc = (req_valid === 1'b1) && (req_ready === 1'b1);
        a   = req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend = 1'b1; pend_addr = a; pend_cnt = cur_lat;
        end
        if (pend && pend_cnt == 0) begin
            rsp_valid = 1'b1; rsp_data = mem_word(pend_addr); pend = 1'b0;
        end else begin
            rsp_valid = 1'b0;
            if (pend) pend_cnt--;
        end
    endtask

    initial begin
        logic [31:0] ei;
        rst_n = 0; req_ready = 0; rsp_valid = 0; rsp_data = '0; ir = 0; rdr_v = 0; rdr_pc = '0;
        w_rst_n = 0; w_req_ready = 1; w_rsp_valid = 0; w_rsp_data = '0; w_ir = 1; w_rdr_v = 0; w_rdr_pc = '0;

        //   rst rr ir rv rpc      lat  req addr     iv ipc      instr          f  c
        add(0, 0, 0, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(0, 0, 0, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h4,   1, 32'h0,   32'h0050_0093, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   32'h0050_0093, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h4,   0, 32'h0,   32'h0050_0093, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h8,   1, 32'h4,   32'h00A0_0113, 0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 1, 0, 0, 32'h0, 0, 0, 32'h8,   1, 32'h4,   32'h00A0_0113, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h8,   0, 32'h4,   32'h00A0_0113, 0, 0);
        add(1, 1, 1, 1, 32'h100, 0,   0, 32'h100, 0, 32'h4,   32'h00A0_0113, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h100, 0, 32'h4,   32'h00A0_0113, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h100, 0, 32'h4,   32'h00A0_0113, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h104, 1, 32'h100, 32'h0010_0513, 0, 0);
        add(1, 1, 1, 1, 32'h102, 0,   0, 32'h102, 0, 32'h100, 32'h0010_0513, 1, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h102, 0, 32'h100, 32'h0010_0513, 1, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h102, 0, 32'h100, 32'h0010_0513, 1, 0);
        add(1, 1, 1, 1, 32'h200, 0,   1, 32'h200, 0, 32'h100, 32'h0010_0513, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h200, 0, 32'h100, 32'h0010_0513, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h204, 1, 32'h200, 32'h0020_0593, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h204, 0, 32'h200, 32'h0020_0593, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h204, 0, 32'h200, 32'h0020_0593, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h208, 0, 32'h204, 32'h0000_4501, 1, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h208, 0, 32'h204, 32'h0000_4501, 1, 1);
        add(1, 1, 1, 1, 32'h0,   0,   1, 32'h0,   0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 0, 32'h0,   2,   0, 32'h0,   0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 1, 32'h10,  0,   0, 32'h10,  0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h10,  0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h10,  0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h10,  0, 32'h204, 32'h0000_4501, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h14,  1, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 1, 0, 1, 32'h40,  0,   1, 32'h40,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h40,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 1, 32'h80,  0,   1, 32'h80,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 0, 1, 0, 32'h0,   0,   1, 32'h80,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 0, 1, 1, 32'h84,  0,   1, 32'h84,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h84,  0, 32'h10,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h88,  1, 32'h84,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h88,  0, 32'h84,  32'h0000_0013, 0, 1);
        add(1, 1, 1, 1, 32'h8A,  1,   0, 32'h8A,  0, 32'h84,  32'h0000_0013, 1, 0);
        add(1, 1, 1, 1, 32'hC0,  0,   0, 32'hC0,  0, 32'h84,  32'h0000_0013, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'hC0,  0, 32'h84,  32'h0000_0013, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'hC0,  0, 32'h84,  32'h0000_0013, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'hC4,  1, 32'hC0,  32'h0000_0013, 0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'hC4,  0, 32'hC0,  32'h0000_0013, 0, 0);
        add(1, 1, 1, 0, 32'h0,   1,   0, 32'hC4,  0, 32'hC0,  32'h0000_0013, 0, 0);
        add(0, 1, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   32'h0,         0, 0);
        add(1, 1, 1, 0, 32'h0,   0,   0, 32'h4,   1, 32'h0,   32'h0050_0093, 0, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            rst_n = vecs[r].rst_n; req_ready = vecs[r].rr; ir = vecs[r].ir;
            rdr_v = vecs[r].rv; rdr_pc = vecs[r].rpc; cur_lat = vecs[r].lat;
            tick();
            ei = vecs[r].einstr;
            chk("req_valid",   r, {31'd0, req_valid}, {31'd0, vecs[r].ereq});
            chk("req_addr",    r, req_addr,           vecs[r].eaddr);
            chk("instr_valid", r, {31'd0, iv},        {31'd0, vecs[r].eiv});
            chk("instr_pc",    r, ipc,                vecs[r].eipc);
            chk("instr",       r, instr,              ei);
            chk("opcode",      r, {27'd0, opcode},    {27'd0, ei[6:2]});
            chk("fetch_fault", r, {31'd0, fault},     {31'd0, vecs[r].ef});
            chk("fault_cause", r, {31'd0, cause},     {31'd0, vecs[r].ec});
        end
        rdr_v = 0;

        // Reset vector at the top of the address space: second fetch wraps to 0.
        w_rst_n = 1;
        @(posedge clk); #1;
        chk("wrap_req_valid0", 0, {31'd0, w_req_valid}, 32'd1);
        chk("wrap_req_addr0",  0, w_req_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        w_rsp_valid = 1; w_rsp_data = 32'h0000_0013;
        @(posedge clk); #1;
        w_rsp_valid = 0;
        chk("wrap_instr_valid", 1, {31'd0, w_iv}, 32'd1);
        chk("wrap_instr_pc",    1, w_ipc, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_req_valid1", 2, {31'd0, w_req_valid}, 32'd1);
        chk("wrap_req_addr1",  2, w_req_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
